ten_wgt_x_stage: RTL and testbench



---
 rtl/ten_wgt_x_stage_pkg.sv | 27 ++
 rtl/ten_wgt_x_mac.sv | 53 +++++
 rtl/ten_wgt_x_stage.sv | 130 +++++++++++++
 tb/tb_ten_wgt_x_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ten_wgt_x_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ten_wgt_x_stage_pkg
// Brief    : Shared optical-flow constants and types for the horizontal
//            tensor-weighting stage (filter weights, beat layout, FSM states).
// Revision : 1.0 - initial release
// ============================================================================
package ten_wgt_x_stage_pkg;

    // Symmetric 3-tap weights, unsigned Q0.16 (2*W0 + W1 < 1.0, so no overflow)
    localparam int unsigned W0_Q16    = 21253;
    localparam int unsigned W1_Q16    = 23023;

    localparam int unsigned TENSOR_CW = 32;
    localparam int unsigned TENSOR_NC = 6;

    typedef logic signed [TENSOR_CW-1:0] tensor_comp_t;
    typedef tensor_comp_t [TENSOR_NC-1:0] tensor_beat_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } wgt_state_t;

endpackage
`default_nettype wire

// File: rtl/ten_wgt_x_mac.sv
`default_nettype none
// ============================================================================
// Module   : ten_wgt_x_mac
// Brief    : Combinational 3-tap symmetric weighting of one tensor component,
//            rounded half up and truncated back to CW bits.
// Revision : 1.0 - initial release
// ============================================================================
module ten_wgt_x_mac
    import ten_wgt_x_stage_pkg::*;
#(
    parameter int CW = TENSOR_CW
) (
    input  logic signed [CW-1:0] tap_l,
    input  logic signed [CW-1:0] tap_c,
    input  logic signed [CW-1:0] tap_r,
    output logic signed [CW-1:0] result
);

    // Product width: CW signed times a 17-bit non-negative weight
    localparam int PW = CW + 17;
    // Sum width: one guard bit over the product width
    localparam int SW = PW + 1;

    localparam logic signed [PW-1:0] C_W0    = PW'(W0_Q16);
    localparam logic signed [PW-1:0] C_W1    = PW'(W1_Q16);
    localparam logic signed [SW-1:0] C_ROUND = SW'(32768);

    logic signed [PW-1:0] w_tap_l_x;
    logic signed [PW-1:0] w_tap_c_x;
    logic signed [PW-1:0] w_tap_r_x;
    logic signed [PW-1:0] w_prod_l;
    logic signed [PW-1:0] w_prod_c;
    logic signed [PW-1:0] w_prod_r;
    logic signed [SW-1:0] w_sum;

    assign w_tap_l_x = {{(PW-CW){tap_l[CW-1]}}, tap_l};
    assign w_tap_c_x = {{(PW-CW){tap_c[CW-1]}}, tap_c};
    assign w_tap_r_x = {{(PW-CW){tap_r[CW-1]}}, tap_r};

    assign w_prod_l  = w_tap_l_x * C_W0;
    assign w_prod_c  = w_tap_c_x * C_W1;
    assign w_prod_r  = w_tap_r_x * C_W0;

    assign w_sum = {w_prod_l[PW-1], w_prod_l}
                 + {w_prod_c[PW-1], w_prod_c}
                 + {w_prod_r[PW-1], w_prod_r}
                 + C_ROUND;

    // Arithmetic shift drops the Q0.16 fraction; the result always fits in CW
    assign result = CW'(w_sum >>> 16);

endmodule
`default_nettype wire

// File: rtl/ten_wgt_x_stage.sv
`default_nettype none
// ============================================================================
// Module   : ten_wgt_x_stage
// Brief    : Horizontal tensor-weighting stage. Applies a symmetric 3-tap
//            horizontal filter to each of NC components per pixel, with zero
//            taps outside the line; one output beat per input pixel.
// Revision : 1.0 - initial release
// ============================================================================
module ten_wgt_x_stage
    import ten_wgt_x_stage_pkg::*;
#(
    parameter int WIDTH = 640,
    parameter int CW    = TENSOR_CW,
    parameter int NC    = TENSOR_NC
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic [NC*CW-1:0] tensor_y_stream_tdata,
    input  logic             tensor_y_stream_tvalid,
    output logic             tensor_y_stream_tready,
    output logic [NC*CW-1:0] tensor_stream_tdata,
    output logic             tensor_stream_tvalid,
    input  logic             tensor_stream_tready
);

    localparam int               CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_LAST_COL = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_COL_ONE  = CNT_W'(1);

    wgt_state_t         r_state;
    logic [NC*CW-1:0]   r_prev;
    logic [NC*CW-1:0]   r_cur;
    logic [NC*CW-1:0]   r_out_data;
    logic               r_out_valid;
    logic [CNT_W-1:0]   r_col;

    logic               w_slot_free;
    logic               w_in_ready;
    logic               w_accept;
    logic [NC*CW-1:0]   w_next_tap;
    logic [NC*CW-1:0]   w_result;

    assign w_slot_free = !r_out_valid || tensor_stream_tready;
    assign w_accept    = tensor_y_stream_tvalid && w_in_ready;

    // Right-hand tap is the incoming pixel while streaming and zero when flushing
    assign w_next_tap  = (r_state == RUN) ? tensor_y_stream_tdata : '0;

    // Input ready: always in FILL, tied to the output slot in RUN, never in FLUSH
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            FILL:    w_in_ready = 1'b1;
            RUN:     w_in_ready = w_slot_free;
            FLUSH:   w_in_ready = 1'b0;
            default: w_in_ready = 1'b0;
        endcase
    end

    genvar g;
    generate
        for (g = 0; g < NC; g++) begin : g_mac
            ten_wgt_x_mac #(
                .CW (CW)
            ) u_mac (
                .tap_l  (r_prev[g*CW +: CW]),
                .tap_c  (r_cur[g*CW +: CW]),
                .tap_r  (w_next_tap[g*CW +: CW]),
                .result (w_result[g*CW +: CW])
            );
        end
    endgenerate

    // Line FSM: shifts the tap window, tracks the column, and owns the output register
    always_ff @(posedge aclk) begin
        if (arst) begin
            r_state     <= FILL;
            r_prev      <= '0;
            r_cur       <= '0;
            r_col       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            // A completed handshake empties the slot unless a new result loads below
            if (r_out_valid && tensor_stream_tready) begin
                r_out_valid <= 1'b0;
            end
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_cur   <= tensor_y_stream_tdata;
                        r_col   <= C_COL_ONE;
                        r_state <= (WIDTH == 1) ? FLUSH : RUN;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        r_out_data  <= w_result;
                        r_out_valid <= 1'b1;
                        r_prev      <= r_cur;
                        r_cur       <= tensor_y_stream_tdata;
                        if (r_col == C_LAST_COL) begin
                            r_state <= FLUSH;
                        end else begin
                            r_col <= r_col + C_COL_ONE;
                        end
                    end
                end
                FLUSH: begin
                    if (w_slot_free) begin
                        r_out_data  <= w_result;
                        r_out_valid <= 1'b1;
                        r_prev      <= '0;
                        r_col       <= '0;
                        r_state     <= FILL;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    assign tensor_y_stream_tready = w_in_ready;
    assign tensor_stream_tdata    = r_out_data;
    assign tensor_stream_tvalid   = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_ten_wgt_x_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ten_wgt_x_stage
// Brief    : Self-checking bench for ten_wgt_x_stage (WIDTH=4 and WIDTH=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ten_wgt_x_stage;

    localparam int W  = 4;
    localparam int BW = 192;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] out_data;
    logic          out_valid;
    logic          ds_ready;

    logic [BW-1:0] in1_data;
    logic          in1_valid;
    logic          in1_ready;
    logic [BW-1:0] out1_data;
    logic          out1_valid;
    logic          ds1_ready;

    ten_wgt_x_stage #(.WIDTH(W)) dut (
        .aclk                   (clk),
        .arst                   (rst),
        .tensor_y_stream_tdata  (in_data),
        .tensor_y_stream_tvalid (in_valid),
        .tensor_y_stream_tready (in_ready),
        .tensor_stream_tdata    (out_data),
        .tensor_stream_tvalid   (out_valid),
        .tensor_stream_tready   (ds_ready)
    );

    ten_wgt_x_stage #(.WIDTH(1)) dut_w1 (
        .aclk                   (clk),
        .arst                   (rst),
        .tensor_y_stream_tdata  (in1_data),
        .tensor_y_stream_tvalid (in1_valid),
        .tensor_y_stream_tready (in1_ready),
        .tensor_stream_tdata    (out1_data),
        .tensor_stream_tvalid   (out1_valid),
        .tensor_stream_tready   (ds1_ready)
    );

    typedef struct packed {
        logic [3:0][31:0] pix;
        logic [3:0][31:0] exp;
    } vec_t;

    vec_t          tbl [4];
    int            checks   = 0;
    int            failures = 0;
    logic [BW-1:0] src_q[$];
    logic [BW-1:0] got_q[$];
    logic [BW-1:0] exp_q[$];
    int            acc_cyc[$];
    int            got_cyc[$];
    int            cyc;
    int            rdy_mode;
    int            gap_pct;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk_beat(input logic [31:0] v);
        logic [BW-1:0] b;
        b = '0;
        b[31:0] = v;
        return b;
    endfunction

    // Reference: plain integer arithmetic of the weighted sum, round half up
    function automatic logic [BW-1:0] ref_px(input logic [BW-1:0] l, input logic [BW-1:0] c,
                                             input logic [BW-1:0] r);
        logic [BW-1:0] o;
        longint a, b, d, s;
        o = '0;
        for (int k = 0; k < 6; k++) begin
            a = longint'($signed(l[k*32 +: 32]));
            b = longint'($signed(c[k*32 +: 32]));
            d = longint'($signed(r[k*32 +: 32]));
            s = (21253 * a + 23023 * b + 21253 * d + 32768) >>> 16;
            o[k*32 +: 32] = s[31:0];
        end
        return o;
    endfunction

    task automatic model_line(input logic [BW-1:0] line [W]);
        logic [BW-1:0] l, r;
        for (int x = 0; x < W; x++) begin
            l = (x > 0)     ? line[x-1] : '0;
            r = (x < W - 1) ? line[x+1] : '0;
            exp_q.push_back(ref_px(l, line[x], r));
        end
    endtask

    task automatic clear_q();
        src_q.delete(); got_q.delete(); exp_q.delete();
        acc_cyc.delete(); got_cyc.delete();
        cyc = 0;
    endtask

    // One cycle: drive at negedge, sample handshakes just after, edge follows
    task automatic step();
        @(negedge clk);
        in_valid = (src_q.size() > 0) && ($urandom_range(99) >= gap_pct);
        in_data  = (src_q.size() > 0) ? src_q[0] : '0;
        case (rdy_mode)
            1:       ds_ready = ($urandom_range(1) == 1);
            2:       ds_ready = !(cyc >= 3 && cyc <= 7);
            default: ds_ready = 1'b1;
        endcase
        #1;
        if (in_valid && in_ready) begin
            void'(src_q.pop_front());
            acc_cyc.push_back(cyc);
        end
        if (out_valid && ds_ready) begin
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic run_and_check(input int n_exp, input string name);
        int budget;
        budget = 0;
        while ((src_q.size() > 0 || got_q.size() < n_exp) && budget < 400) begin
            step();
            budget++;
        end
        if (budget >= 400) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d beats expected %0d", name, got_q.size(), n_exp);
        end
        rdy_mode = 0;
        repeat (4) step();
        chk($sformatf("%s_count", name), BW'(got_q.size()), BW'(n_exp));
        for (int i = 0; i < n_exp && i < got_q.size(); i++) begin
            chk($sformatf("%s_beat%0d", name, i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] line [W];

        tbl[0].pix = {4{32'd65536}};
        tbl[0].exp = {32'd44276, 32'd65529, 32'd65529, 32'd44276};
        tbl[1].pix = {4{32'hFFFF_0000}};
        tbl[1].exp = {32'(-44276), 32'(-65529), 32'(-65529), 32'(-44276)};
        tbl[2].pix = {32'd0, 32'd0, 32'd1, 32'd0};
        tbl[2].exp = {32'd0, 32'd0, 32'd0, 32'd0};
        tbl[3].pix = {32'd0, 32'd0, 32'd65536, 32'd0};
        tbl[3].exp = {32'd0, 32'd21253, 32'd23023, 32'd21253};

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; ds_ready = 1'b1;
        in1_valid = 1'b0; in1_data = '0; ds1_ready = 1'b1;
        rdy_mode = 0; gap_pct = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tvalid", BW'(out_valid), '0);
        chk("rst_tdata", out_data, '0);
        chk("rst_in_ready", BW'(in_ready), BW'(1));
        @(negedge clk);
        rst = 1'b0;

        // Table vectors: one line each, continuous input, downstream always ready
        for (int v = 0; v < 4; v++) begin
            clear_q();
            rdy_mode = 0;
            for (int x = 0; x < W; x++) begin
                src_q.push_back(mk_beat(tbl[v].pix[x]));
                exp_q.push_back(mk_beat(tbl[v].exp[x]));
            end
            run_and_check(W, $sformatf("tbl%0d", v));
            if (v == 0 && got_cyc.size() == W && acc_cyc.size() == W) begin
                chk("lat_last_px", BW'(got_cyc[W-1] - acc_cyc[W-1]), BW'(2));
                chk("lat_first_px", BW'(got_cyc[0] - acc_cyc[1]), BW'(1));
                chk("out_no_bubble", BW'(got_cyc[W-1] - got_cyc[0]), BW'(W - 1));
            end
        end

        // Two back-to-back lines with downstream stalled for cycles 3..7
        clear_q();
        rdy_mode = 2;
        for (int n = 0; n < 2; n++) begin
            for (int x = 0; x < W; x++) begin
                src_q.push_back(mk_beat(tbl[0].pix[x]));
                exp_q.push_back(mk_beat(tbl[0].exp[x]));
            end
        end
        run_and_check(2 * W, "bp");

        // Reset mid-line: two pixels in, output stalled, then reset
        @(negedge clk);
        in_valid = 1'b1; in_data = mk_beat(32'd65536); ds_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("mid_tvalid", BW'(out_valid), BW'(1));
        chk("mid_x0", out_data, mk_beat(32'd44276));
        chk("stall_in_ready", BW'(in_ready), '0);
        ds_ready = 1'b1;
        #1;
        chk("unstall_in_ready", BW'(in_ready), BW'(1));
        ds_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_drop_tvalid", BW'(out_valid), '0);
        chk("rst_drop_tdata", out_data, '0);
        rst = 1'b0;
        clear_q();
        rdy_mode = 0;
        for (int x = 0; x < W; x++) begin
            src_q.push_back(mk_beat(tbl[0].pix[x]));
            exp_q.push_back(mk_beat(tbl[0].exp[x]));
        end
        run_and_check(W, "post_rst");

        // Randomized full-range lines, random input gaps and downstream stalls
        clear_q();
        rdy_mode = 1;
        gap_pct = 25;
        for (int n = 0; n < 3; n++) begin
            for (int x = 0; x < W; x++) begin
                for (int k = 0; k < 6; k++) line[x][k*32 +: 32] = $urandom;
                src_q.push_back(line[x]);
            end
            model_line(line);
        end
        run_and_check(3 * W, "rand");
        gap_pct = 0;

        // WIDTH=1 build: single pixel line, one FLUSH cycle with input not ready
        @(negedge clk);
        in1_valid = 1'b1; in1_data = mk_beat(32'd65536); ds1_ready = 1'b1;
        #1;
        chk("w1_ready_fill", BW'(in1_ready), BW'(1));
        @(negedge clk);
        in1_valid = 1'b0;
        #1;
        chk("w1_ready_flush", BW'(in1_ready), '0);
        chk("w1_valid_early", BW'(out1_valid), '0);
        @(negedge clk);
        #1;
        chk("w1_valid", BW'(out1_valid), BW'(1));
        chk("w1_data", out1_data, mk_beat(32'd23023));
        chk("w1_ready_back", BW'(in1_ready), BW'(1));
        @(negedge clk);
        #1;
        chk("w1_valid_done", BW'(out1_valid), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
